// File: rtl/fei4_rx_frame_decode.sv
// FE-I4 receiver frame decoder: 8b/10b decode with running-disparity check,
// SOF/EOF framing and packing of data bytes into 24-bit records.
module fei4_rx_frame_decode #(
  parameter int DSIZE = 10,
  parameter int CNT_W = 8
) (
  input  logic             wclk,
  input  logic             reset_n,
  input  logic             sync_ready,
  input  logic [DSIZE-1:0] data,
  input  logic             clr_cnt,
  output logic [23:0]      data_out,
  output logic             data_valid,
  output logic             frame_active,
  output logic [CNT_W-1:0] code_err_cnt,
  output logic [CNT_W-1:0] frame_err_cnt
);

  typedef enum logic [2:0] {SYM_DATA, SYM_IDLE, SYM_SOF, SYM_EOF, SYM_ERR} sym_t;
  typedef enum logic [1:0] {WAIT_SYNC, IDLE, FRAME} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // vld_pipe[0]: sampled sync_ready, vld_pipe[1]: stage-1 symbol present
  logic [DSIZE-1:0] rx_sym;
  logic [1:0]       vld_pipe;
  sym_t             s1_kind;
  logic [7:0]       s1_byte;
  logic             rd_known, rd_pos;

  logic [5:0] six;
  logic [3:0] four;
  logic [4:0] dec5;
  logic [2:0] dec3;
  logic       ok6, ok4, k_other;
  logic [2:0] p6, p4;
  logic       pos6, neg6, pos4, neg4;
  logic       rd_mid_pos, rd_nxt_pos, rd_nxt_known, disp_err;
  sym_t       kind;

  assign six  = rx_sym[9:4];
  assign four = rx_sym[3:0];

  // 5b/6b decode of abcdei; K28 patterns are handled separately
  always_comb begin
    dec5 = 5'd0;
    ok6  = 1'b1;
    case (six)
      6'b100111, 6'b011000: dec5 = 5'd0;
      6'b011101, 6'b100010: dec5 = 5'd1;
      6'b101101, 6'b010010: dec5 = 5'd2;
      6'b110001:            dec5 = 5'd3;
      6'b110101, 6'b001010: dec5 = 5'd4;
      6'b101001:            dec5 = 5'd5;
      6'b011001:            dec5 = 5'd6;
      6'b111000, 6'b000111: dec5 = 5'd7;
      6'b111001, 6'b000110: dec5 = 5'd8;
      6'b100101:            dec5 = 5'd9;
      6'b010101:            dec5 = 5'd10;
      6'b110100:            dec5 = 5'd11;
      6'b001101:            dec5 = 5'd12;
      6'b101100:            dec5 = 5'd13;
      6'b011100:            dec5 = 5'd14;
      6'b010111, 6'b101000: dec5 = 5'd15;
      6'b011011, 6'b100100: dec5 = 5'd16;
      6'b100011:            dec5 = 5'd17;
      6'b010011:            dec5 = 5'd18;
      6'b110010:            dec5 = 5'd19;
      6'b001011:            dec5 = 5'd20;
      6'b101010:            dec5 = 5'd21;
      6'b011010:            dec5 = 5'd22;
      6'b111010, 6'b000101: dec5 = 5'd23;
      6'b110011, 6'b001100: dec5 = 5'd24;
      6'b100110:            dec5 = 5'd25;
      6'b010110:            dec5 = 5'd26;
      6'b110110, 6'b001001: dec5 = 5'd27;
      6'b001110:            dec5 = 5'd28;
      6'b101110, 6'b010001: dec5 = 5'd29;
      6'b011110, 6'b100001: dec5 = 5'd30;
      6'b101011, 6'b010100: dec5 = 5'd31;
      default:              ok6  = 1'b0;
    endcase
  end

  // 3b/4b decode of fghj; primary and alternate x.7 both map to 7
  always_comb begin
    dec3 = 3'd0;
    ok4  = 1'b1;
    case (four)
      4'b1011, 4'b0100:                   dec3 = 3'd0;
      4'b1001:                            dec3 = 3'd1;
      4'b0101:                            dec3 = 3'd2;
      4'b1100, 4'b0011:                   dec3 = 3'd3;
      4'b1101, 4'b0010:                   dec3 = 3'd4;
      4'b1010:                            dec3 = 3'd5;
      4'b0110:                            dec3 = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: dec3 = 3'd7;
      default:                            ok4  = 1'b0;
    endcase
  end

  // K23.7/K27.7/K29.7/K30.7 would otherwise pass as data with an alternate x.7
  assign k_other = (four == 4'b1000 && six inside {6'b111010, 6'b110110, 6'b101110, 6'b011110}) ||
                   (four == 4'b0111 && six inside {6'b000101, 6'b001001, 6'b010001, 6'b100001});

  // Sub-block disparity from popcount; each sub-block is checked against RD
  // as it stands after the previous sub-block
  assign p6   = 3'($countones(six));
  assign p4   = 3'($countones(four));
  assign pos6 = p6 > 3'd3;
  assign neg6 = p6 < 3'd3;
  assign pos4 = p4 > 3'd2;
  assign neg4 = p4 < 3'd2;

  assign rd_mid_pos   = pos6 ? 1'b1 : (neg6 ? 1'b0 : rd_pos);
  assign rd_nxt_pos   = pos4 ? 1'b1 : (neg4 ? 1'b0 : rd_mid_pos);
  assign rd_nxt_known = rd_known | pos6 | neg6 | pos4 | neg4;
  assign disp_err     = rd_known && ((pos6 && rd_pos) || (neg6 && !rd_pos) ||
                                     (pos4 && rd_mid_pos) || (neg4 && !rd_mid_pos));

  // Symbol classification: only K28.1/.5/.7 are meaningful control codes
  always_comb begin
    kind = SYM_DATA;
    if (six == 6'b001111 || six == 6'b110000) begin
      case (four)
        4'b1001, 4'b0110: kind = SYM_IDLE;
        4'b1010, 4'b0101: kind = SYM_EOF;
        4'b1000, 4'b0111: kind = SYM_SOF;
        default:          kind = SYM_ERR;
      endcase
    end else if (k_other || !ok6 || !ok4) begin
      kind = SYM_ERR;
    end
    if (disp_err) kind = SYM_ERR;
  end

  // Input sample, stage-1 decode registers and running disparity
  always_ff @(posedge wclk) begin
    if (!reset_n) begin
      rx_sym   <= '0;
      vld_pipe <= '0;
      s1_kind  <= SYM_IDLE;
      s1_byte  <= '0;
      rd_known <= 1'b0;
      rd_pos   <= 1'b0;
    end else begin
      rx_sym   <= data;
      vld_pipe <= {vld_pipe[0], sync_ready};
      s1_kind  <= vld_pipe[0] ? kind : SYM_IDLE;
      s1_byte  <= {dec3, dec5};
      if (vld_pipe[0]) begin
        rd_known <= rd_nxt_known;
        rd_pos   <= rd_nxt_pos;
      end else begin
        rd_known <= 1'b0;
      end
    end
  end

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        store, push, code_inc, frame_inc;
  logic [15:0] part_q;

  // Frame state register
  always_ff @(posedge wclk) begin
    if (!reset_n) begin
      state_q <= WAIT_SYNC;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Frame next-state, byte packing control and error strobes
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    store     = 1'b0;
    push      = 1'b0;
    code_inc  = 1'b0;
    frame_inc = 1'b0;
    if (!vld_pipe[1]) begin
      state_d = WAIT_SYNC;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        WAIT_SYNC: begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end
        IDLE: begin
          case (s1_kind)
            SYM_SOF: begin
              state_d = FRAME;
              idx_d   = 2'd0;
            end
            SYM_DATA, SYM_EOF: frame_inc = 1'b1;
            SYM_ERR:           code_inc  = 1'b1;
            default: ;
          endcase
        end
        FRAME: begin
          case (s1_kind)
            SYM_DATA: begin
              store = 1'b1;
              if (idx_q == 2'd2) begin
                push  = 1'b1;
                idx_d = 2'd0;
              end else begin
                idx_d = idx_q + 2'd1;
              end
            end
            SYM_EOF: begin
              frame_inc = (idx_q != 2'd0);
              state_d   = IDLE;
              idx_d     = 2'd0;
            end
            SYM_SOF: begin
              frame_inc = 1'b1;
              idx_d     = 2'd0;
            end
            SYM_ERR: begin
              code_inc = 1'b1;
              state_d  = IDLE;
              idx_d    = 2'd0;
            end
            default: ;
          endcase
        end
        default: begin
          state_d = WAIT_SYNC;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  assign frame_active = (state_q == FRAME);

  // Byte packing and record output; data_out holds between records
  always_ff @(posedge wclk) begin
    if (!reset_n) begin
      part_q     <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= push;
      if (store && idx_q == 2'd0) part_q[15:8] <= s1_byte;
      if (store && idx_q == 2'd1) part_q[7:0]  <= s1_byte;
      if (push) data_out <= {part_q, s1_byte};
    end
  end

  // Saturating error counters; clear beats a same-cycle increment
  always_ff @(posedge wclk) begin
    if (!reset_n || clr_cnt) begin
      code_err_cnt  <= '0;
      frame_err_cnt <= '0;
    end else begin
      if (code_inc && code_err_cnt != CNT_MAX)   code_err_cnt  <= code_err_cnt + CNT_ONE;
      if (frame_inc && frame_err_cnt != CNT_MAX) frame_err_cnt <= frame_err_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fei4_rx_frame_decode.sv
// Directed bench for fei4_rx_frame_decode: table-driven frame stream plus
// hand-written disparity, sync-loss, saturation and reset sequences.
module tb_fei4_rx_frame_decode;

  logic        wclk = 1'b0;
  logic        reset_n, sync_ready, clr_cnt;
  logic [9:0]  data;
  logic [23:0] data_out;
  logic        data_valid, frame_active;
  logic [7:0]  code_err_cnt, frame_err_cnt;

  fei4_rx_frame_decode #(.DSIZE(10), .CNT_W(8)) dut (
    .wclk(wclk), .reset_n(reset_n), .sync_ready(sync_ready), .data(data),
    .clr_cnt(clr_cnt), .data_out(data_out), .data_valid(data_valid),
    .frame_active(frame_active), .code_err_cnt(code_err_cnt),
    .frame_err_cnt(frame_err_cnt)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int fails  = 0;
  bit tb_rd  = 1'b0;  // 1 = RD+, the bench's own encoder state

  // record monitor
  int          vcount = 0;
  logic [23:0] recs[$];
  always @(negedge wclk) if (data_valid) begin
    vcount++;
    recs.push_back(data_out);
  end

  // 5b/6b RD- forms (abcdei) and 3b/4b RD- forms (fghj)
  localparam logic [5:0] T6 [0:31] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [3:0] T4 [0:7] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};

  function automatic logic [9:0] enc_d(input logic [7:0] b, input bit rd);
    logic [5:0] s6;
    logic [3:0] s4;
    int x, y;
    bit r;
    x  = int'(b[4:0]);
    y  = int'(b[7:5]);
    s6 = T6[x];
    if (rd && ($countones(s6) != 3 || x == 7)) s6 = ~s6;
    r = ($countones(s6) > 3) ? 1'b1 : (($countones(s6) < 3) ? 1'b0 : rd);
    if (y == 7 && ((!r && (x == 17 || x == 18 || x == 20)) || (r && (x == 11 || x == 13 || x == 14))))
      s4 = r ? 4'b1000 : 4'b0111;
    else begin
      s4 = T4[y];
      if (r && ($countones(s4) != 2 || y == 3)) s4 = ~s4;
    end
    return {s6, s4};
  endfunction

  function automatic logic [9:0] enc_k(input int y, input bit rd);
    if (rd) return {6'b110000, (y == 1) ? 4'b0110 : (y == 5) ? 4'b0101 : 4'b0111};
    return {6'b001111, (y == 1) ? 4'b1001 : (y == 5) ? 4'b1010 : 4'b1000};
  endfunction

  task automatic send(input logic [9:0] s);
    data = s;
    @(posedge wclk);
    #1;
    if (sync_ready && reset_n) begin
      if ($countones(s[9:4]) > 3) tb_rd = 1'b1;
      else if ($countones(s[9:4]) < 3) tb_rd = 1'b0;
      if ($countones(s[3:0]) > 2) tb_rd = 1'b1;
      else if ($countones(s[3:0]) < 2) tb_rd = 1'b0;
    end
  endtask

  task automatic sd(input logic [7:0] b); send(enc_d(b, tb_rd)); endtask
  task automatic sk(input int y);         send(enc_k(y, tb_rd)); endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] last_rec();
    if (recs.size() == 0) return 24'hxxxxxx;
    return recs[$];
  endfunction

  typedef struct {
    bit          k;   // 1: K28.b, 0: data byte b
    logic [7:0]  b;
    bit          ev;  // expected data_valid 2 edges later
    logic [23:0] ed;
    bit          ea;
    int          ef;
    int          ec;
  } vec_t;

  function automatic vec_t mk(input bit k, input logic [7:0] b, input bit ev,
                              input logic [23:0] ed, input bit ea, input int ef);
    vec_t v;
    v.k = k; v.b = b; v.ev = ev; v.ed = ed; v.ea = ea; v.ef = ef; v.ec = 0;
    return v;
  endfunction

  localparam int N = 27;
  vec_t vt [N];
  int   v0;

  initial begin
    // good frame, short frame, idle-state violations, SOF inside a frame
    vt[0]  = mk(1, 8'd1, 0, 24'h0, 0, 0);
    vt[1]  = mk(1, 8'd1, 0, 24'h0, 0, 0);
    vt[2]  = mk(1, 8'd1, 0, 24'h0, 0, 0);
    vt[3]  = mk(1, 8'd1, 0, 24'h0, 0, 0);
    vt[4]  = mk(1, 8'd7, 0, 24'h0, 1, 0);
    vt[5]  = mk(0, 8'h12, 0, 24'h0, 1, 0);
    vt[6]  = mk(0, 8'h34, 0, 24'h0, 1, 0);
    vt[7]  = mk(0, 8'h56, 1, 24'h123456, 1, 0);
    vt[8]  = mk(0, 8'hAB, 0, 24'h123456, 1, 0);
    vt[9]  = mk(0, 8'hCD, 0, 24'h123456, 1, 0);
    vt[10] = mk(0, 8'hEF, 1, 24'hABCDEF, 1, 0);
    vt[11] = mk(1, 8'd5, 0, 24'hABCDEF, 0, 0);
    vt[12] = mk(1, 8'd7, 0, 24'hABCDEF, 1, 0);
    vt[13] = mk(0, 8'h11, 0, 24'hABCDEF, 1, 0);
    vt[14] = mk(0, 8'h22, 0, 24'hABCDEF, 1, 0);
    vt[15] = mk(1, 8'd5, 0, 24'hABCDEF, 0, 1);
    vt[16] = mk(1, 8'd1, 0, 24'hABCDEF, 0, 1);
    vt[17] = mk(0, 8'h55, 0, 24'hABCDEF, 0, 2);
    vt[18] = mk(1, 8'd5, 0, 24'hABCDEF, 0, 3);
    vt[19] = mk(1, 8'd7, 0, 24'hABCDEF, 1, 3);
    vt[20] = mk(0, 8'h66, 0, 24'hABCDEF, 1, 3);
    vt[21] = mk(1, 8'd7, 0, 24'hABCDEF, 1, 4);
    vt[22] = mk(0, 8'h77, 0, 24'hABCDEF, 1, 4);
    vt[23] = mk(0, 8'h88, 0, 24'hABCDEF, 1, 4);
    vt[24] = mk(1, 8'd1, 0, 24'hABCDEF, 1, 4);
    vt[25] = mk(0, 8'h99, 1, 24'h778899, 1, 4);
    vt[26] = mk(1, 8'd5, 0, 24'h778899, 0, 4);

    // reset state
    reset_n = 1'b0; sync_ready = 1'b0; clr_cnt = 1'b0; data = '0;
    repeat (3) send(10'h000);
    chk("rst data_out", 32'(data_out), 32'h0);
    chk("rst data_valid", 32'(data_valid), 32'h0);
    chk("rst frame_active", 32'(frame_active), 32'h0);
    chk("rst code_err", 32'(code_err_cnt), 32'h0);
    chk("rst frame_err", 32'(frame_err_cnt), 32'h0);

    reset_n = 1'b1; sync_ready = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      if (i < N) send(vt[i].k ? enc_k(int'(vt[i].b), tb_rd) : enc_d(vt[i].b, tb_rd));
      else       sk(1);
      if (i >= 2) begin
        chk($sformatf("row%0d valid", i - 2), 32'(data_valid), 32'(vt[i-2].ev));
        chk($sformatf("row%0d data", i - 2), 32'(data_out), 32'(vt[i-2].ed));
        chk($sformatf("row%0d active", i - 2), 32'(frame_active), 32'(vt[i-2].ea));
        chk($sformatf("row%0d frame_err", i - 2), 32'(frame_err_cnt), 32'(vt[i-2].ef));
        chk($sformatf("row%0d code_err", i - 2), 32'(code_err_cnt), 32'(vt[i-2].ec));
      end
    end

    // disparity error aborts the frame; stray bytes then count as framing errors
    clr_cnt = 1'b1; sk(1); clr_cnt = 1'b0;
    chk("clr frame_err", 32'(frame_err_cnt), 32'h0);
    chk("clr code_err", 32'(code_err_cnt), 32'h0);
    v0 = vcount;
    sk(7); sd(8'h12);
    send(enc_d(8'h12, ~tb_rd));
    sd(8'h34);
    chk("disp active before", 32'(frame_active), 32'h1);
    sd(8'h56);
    chk("disp active after", 32'(frame_active), 32'h0);
    chk("disp code_err", 32'(code_err_cnt), 32'h1);
    repeat (3) sk(1);
    chk("disp frame_err", 32'(frame_err_cnt), 32'h2);
    chk("disp no record", 32'(vcount), 32'(v0));

    // sync loss mid-frame, then restart with an RD the old state would reject
    v0 = vcount;
    sk(7); sd(8'hA1); sd(8'hA2);
    sync_ready = 1'b0;
    repeat (3) send(10'h000);
    sync_ready = 1'b1;
    tb_rd = ~tb_rd;
    sk(1); sk(1); sk(7);
    sd(8'h01); sd(8'h02); sd(8'h03); sd(8'h04); sd(8'h05); sd(8'h06);
    sk(5); repeat (3) sk(1);
    chk("sync records", 32'(vcount), 32'(v0 + 2));
    chk("sync rec1", 32'(recs.size() >= 2 ? recs[recs.size()-2] : 24'hxxxxxx), 32'h010203);
    chk("sync rec2", 32'(last_rec()), 32'h040506);
    chk("sync code_err", 32'(code_err_cnt), 32'h1);
    chk("sync frame_err", 32'(frame_err_cnt), 32'h2);
    chk("sync active", 32'(frame_active), 32'h0);

    // saturation, then clear colliding with an in-flight increment
    repeat (300) send(10'h000);
    chk("sat code_err", 32'(code_err_cnt), 32'd255);
    clr_cnt = 1'b1; send(10'h000); clr_cnt = 1'b0;
    chk("clr+inc code_err", 32'(code_err_cnt), 32'h0);
    chk("clr+inc frame_err", 32'(frame_err_cnt), 32'h0);
    sync_ready = 1'b0;
    repeat (3) send(10'h000);
    chk("post-clr code_err", 32'(code_err_cnt), 32'h2);
    sync_ready = 1'b1;

    // reset with two bytes of a record pending
    v0 = vcount;
    sk(1); sk(7); sd(8'hB1); sd(8'hB2); sk(1); sk(1);
    chk("pre-rst active", 32'(frame_active), 32'h1);
    reset_n = 1'b0; sd(8'hB3); reset_n = 1'b1;
    chk("midrst data_out", 32'(data_out), 32'h0);
    chk("midrst data_valid", 32'(data_valid), 32'h0);
    chk("midrst active", 32'(frame_active), 32'h0);
    chk("midrst code_err", 32'(code_err_cnt), 32'h0);
    chk("midrst frame_err", 32'(frame_err_cnt), 32'h0);
    sk(1); sd(8'hC1); sd(8'hC2); sd(8'hC3); repeat (3) sk(1);
    chk("after rst needs SOF", 32'(frame_err_cnt), 32'h3);
    chk("after rst no record", 32'(vcount), 32'(v0));
    sk(7); sd(8'hC1); sd(8'hC2); sd(8'hC3); sk(5); repeat (3) sk(1);
    chk("after rst record cnt", 32'(vcount), 32'(v0 + 1));
    chk("after rst record", 32'(last_rec()), 32'hC1C2C3);
    chk("after rst code_err", 32'(code_err_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/fei4_rx_frame_decode.md
# fei4_rx_frame_decode

Downstream stage of the FE-I4 receiver symbol synchroniser. Takes the aligned 10-bit 8b/10b symbols it produces, one per word clock:
- decodes each symbol and checks running disparity;
- tracks SOF/EOF framing;
- packs in-frame data bytes into 24-bit FE-I4 records for the receiver FIFO.

It also keeps saturating error counters for slow-control readout.

## Interface
Parameters:
- DSIZE, 10, symbol width; only 10 is supported.
- CNT_W, 8, width of each error counter.

Ports:
- wclk  in  1  word clock; one symbol per cycle.
- reset_n  in  1  synchronous, active-low reset.
- sync_ready  in  1  symbol alignment locked; symbols are valid only while high.
- data  in  DSIZE  aligned symbol, bit 9 = 8b/10b bit a, bit 0 = bit j.
- clr_cnt  in  1  synchronous clear of both counters.
- data_out  out  24  record, first byte of the frame group in [23:16].
- data_valid  out  1  one-cycle strobe, data_out valid.
- frame_active  out  1  high between an accepted SOF and its EOF or abort.
- code_err_cnt  out  CNT_W  invalid symbols plus disparity errors, saturating.
- frame_err_cnt  out  CNT_W  framing violations, saturating.

## Operation
**Decode**
- Split the symbol into 6b (abcdei = data[9:4]) and 4b (fghj = data[3:0]).
- Decode with the standard 5b/6b and 3b/4b tables to byte HGFEDCBA, where A = bit a.
- Recognised K codes: K28.1 = idle, K28.7 = SOF, K28.5 = EOF. Any other K code is a code error.
- Invalid sub-block (no table entry) is a code error.

**Running disparity (RD)**
- RD is unknown after reset and whenever sync_ready is low.
- The first valid symbol after sync_ready rises sets RD without a check.
- After that, each sub-block must be neutral or of the polarity opposite to the current RD. A violation is a code error.
- RD always updates from the received sub-blocks, including erroneous ones.

**Frame state machine:** WAIT_SYNC, IDLE, FRAME. A 2-bit byte index runs 0..2.
- WAIT_SYNC → IDLE when sync_ready = 1.
- sync_ready = 0 in any state → WAIT_SYNC. Any partial record is discarded, no counter changes, RD becomes unknown.
- IDLE:
  - SOF → FRAME, index = 0.
  - Idle → stay.
  - Data byte or EOF → frame_err +1, stay.
- FRAME:
  - Data byte → placed at [23:16], [15:8], [7:0] for index 0, 1, 2. At index 2, data_valid pulses and index wraps to 0.
  - Idle → ignored, stay.
  - EOF with index = 0 → IDLE.
  - EOF with index ≠ 0 → frame_err +1, partial record dropped, IDLE.
  - SOF → frame_err +1, partial record dropped, stay in FRAME with index = 0.
- Code error in any state except WAIT_SYNC → code_err +1. In FRAME it also aborts the frame: partial record dropped, → IDLE.

**Counters**
- Saturate at 2^CNT_W − 1.
- clr_cnt has priority over an increment in the same cycle; the result is 0.

## Timing
- Pipeline:
  - Stage 1 registers the decoded byte plus K, error and SOF/EOF/idle flags.
  - Stage 2 runs the FSM, packing and outputs.
- A symbol sampled at edge n has its effect visible after edge n+2.
- Record completion: data_out and data_valid update after edge n+2. data_valid is high for exactly one cycle.
- data_out holds its last value when data_valid = 0.
- Counter increments become visible after edge n+2.
- frame_active rises after edge n+2 for SOF and falls after edge n+2 for EOF or abort.
- sync_ready is sampled alongside data, so a deasserting edge takes effect with the same 2-cycle latency. The stage-1 flag derived from a symbol sampled while sync_ready = 0 is forced to "no symbol".
- Reset (reset_n = 0 at an edge):
  - data_out = 0, data_valid = 0, frame_active = 0, both counters = 0;
  - state = WAIT_SYNC, RD unknown, pipeline flags cleared.
  - Applies mid-frame as well; no partial output.
- No backpressure; the consumer accepts every data_valid.

## Test plan
- **Good frame:** sync_ready = 1, then K28.1 ×4, K28.7, D(0x12), D(0x34), D(0x56), D(0xAB), D(0xCD), D(0xEF), K28.5, all disparity-correct → data_out = 0x123456 then 0xABCDEF, each a one-cycle data_valid 2 cycles after the third byte; frame_active drops 2 cycles after EOF; counters 0.
- **Short frame:** K28.7, 0x11, 0x22, K28.5 → no data_valid, frame_err_cnt = 1, IDLE.
- **Disparity error:** within a frame, send 0x12 encoded with the wrong RD → code_err_cnt = 1, frame aborted, frame_active = 0, the following bytes before the next SOF increment frame_err_cnt.
- **Sync loss:** sync_ready low after 2 data bytes of a frame → no output, counters unchanged; after sync_ready returns, a full frame decodes normally (the first symbol is not disparity-checked).
- **Saturation:** 300 invalid symbols with CNT_W = 8 → code_err_cnt = 255; clr_cnt asserted together with another error → 0.
- **Reset:** reset_n low mid-frame with index = 2 pending → all outputs 0, no data_valid, next SOF is required.
